// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO pair: shift-add multiply,
// restoring divide, multiply-accumulate, divide-by-zero early-out and MTHI/MTLO.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;

  logic             is_div_q, is_madd_q, dbz_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0] mag_a, mag_b, base_hi, base_lo;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic             accept, accept_arith, op_signed, op_div, b_zero, last;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  assign a_s          = a;
  assign b_s          = b;
  assign busy         = (state != IDLE);
  assign accept       = start && (state == IDLE);
  assign accept_arith = accept && !(op[2] && op[1]);
  assign op_signed    = ~op[0];
  assign op_div       = (op == 3'd2) || (op == 3'd3);
  assign b_zero       = (b == '0);
  assign last         = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept_arith) state_nx = (op_div && b_zero) ? FIX : CALC;
      CALC: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Iteration step: multiply shifts the multiplier out of acc_lo while the
  // product grows into acc_hi; divide shifts the dividend into the remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    if (is_div_q) begin
      step_hi = div_ge ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction and accumulate; the zero-divisor case restores a from its magnitude.
  always_comb begin
    prod = cond_neg2({acc_hi, acc_lo}, neg_res_q) + (is_madd_q ? {base_hi, base_lo} : '0);
    if (dbz_q) begin
      fix_hi = cond_neg(mag_a, neg_rem_q);
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = cond_neg(acc_hi, neg_rem_q);
      fix_lo = cond_neg(acc_lo, neg_res_q);
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state       <= state_nx;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == CALC) cnt <= cnt + 1'b1;
      else               cnt <= '0;
      if (accept && op == 3'd6) hi <= a;
      if (accept && op == 3'd7) lo <= a;
      if (state == FIX && !abort) begin
        hi          <= fix_hi;
        lo          <= fix_lo;
        done        <= 1'b1;
        div_by_zero <= dbz_q;
      end
    end
  end

  // Operand capture at the accept edge, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept_arith) begin
      is_div_q  <= op_div;
      is_madd_q <= (op == 3'd4) || (op == 3'd5);
      dbz_q     <= op_div && b_zero;
      neg_res_q <= op_signed && (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
      neg_rem_q <= op_signed && a_s[WIDTH-1];
      mag_a     <= magnitude(a_s, op_signed);
      mag_b     <= magnitude(b_s, op_signed);
      base_hi   <= hi;
      base_lo   <= lo;
      acc_hi    <= '0;
      acc_lo    <= op_div ? magnitude(a_s, op_signed) : magnitude(b_s, op_signed);
    end else if (state == CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// abort/reset/MTHI/MTLO sequences, and randomized ops against a 64-bit model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk, rst, start, abort;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] mref;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    logic        edz;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y,
                                        input logic [63:0] cur);
    longint sx, sy, ux, uy, q, r;
    sx = $signed(x); sy = $signed(y);
    ux = {32'b0, x}; uy = {32'b0, y};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return 64'(ux * uy);
      3'd2, 3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == 3'd2) begin q = sx / sy; r = sx % sy; end
        else           begin q = ux / uy; r = ux % uy; end
        return {r[31:0], q[31:0]};
      end
      3'd4: return cur + 64'(sx * sy);
      3'd5: return cur + 64'(ux * uy);
      3'd6: return {x, cur[31:0]};
      default: return {cur[63:32], x};
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called on a negedge; returns on the negedge where done is seen (or timeout).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y,
                        output int lat, output int bcnt);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, seen;
    logic [63:0] exp;
    logic        edz;

    tbl[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1] = '{3'd0, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
    tbl[2] = '{3'd4, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFDC, 1'b0};
    tbl[3] = '{3'd2, 32'hFFFF_FFEF, 32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    tbl[4] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    tbl[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[6] = '{3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};

    rst = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_ctl", {61'b0, busy, done, div_by_zero}, 64'h0);
    rst = 1'b0;
    mref = '0;

    // Directed vectors; each op after the first starts on the done cycle of the previous one.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcnt);
      check($sformatf("vec%0d_hilo", i), {hi, lo}, {tbl[i].eh, tbl[i].el});
      check($sformatf("vec%0d_dbz", i), {63'b0, div_by_zero}, {63'b0, tbl[i].edz});
      check($sformatf("vec%0d_latency", i), 64'(lat), tbl[i].edz ? 64'd1 : 64'd33);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), tbl[i].edz ? 64'd1 : 64'd33);
      mref = {tbl[i].eh, tbl[i].el};
      if (i == 0) begin
        @(negedge clk);
        check("done_pulse_width", {62'b0, done, busy}, 64'h0);
      end
    end

    // Abort mid-multiply, with an ignored start while busy.
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("start_while_busy_busy", {63'b0, busy}, 64'h1);
    check("start_while_busy_hilo", {hi, lo}, mref);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'h0);
    check("abort_hilo", {hi, lo}, mref);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      exp = model(o, x, y, mref);
      if (o >= 3'd6) begin
        start = 1'b1; op = o; a = x;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("rnd%0d_mt_hilo", i), {hi, lo}, exp);
        check($sformatf("rnd%0d_mt_ctl", i), {62'b0, busy, done}, 64'h0);
      end else begin
        edz = (o == 3'd2 || o == 3'd3) && (y == 0);
        run_op(o, x, y, lat, bcnt);
        check($sformatf("rnd%0d_op%0d_hilo", i, o), {hi, lo}, exp);
        check($sformatf("rnd%0d_dbz", i), {63'b0, div_by_zero}, {63'b0, edz});
        check($sformatf("rnd%0d_latency", i), 64'(lat), edz ? 64'd1 : 64'd33);
      end
      mref = exp;
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midop_reset_hilo", {hi, lo}, 64'h0);
    check("midop_reset_ctl", {61'b0, busy, done, div_by_zero}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    start = 1'b1; op = 3'd6; a = 32'hA5A5_A5A5;
    @(negedge clk);
    check("mthi_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h0});
    check("mthi_ctl", {62'b0, busy, done}, 64'h0);
    op = 3'd7; a = 32'h5A5A_5A5A;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});
    check("mtlo_ctl", {62'b0, busy, done}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit that owns the HI/LO register pair for the Mini-MIPS core.
- It replaces single-cycle HI/LO arithmetic with a multi-cycle engine that has a start/busy/done handshake the core stalls on.
- Adds multiply-accumulate, divide-by-zero detection, abort, and direct HI/LO writes.
- Sits beside the ALU, fed from register-file read data, with results read back through hi/lo.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; accepted only when busy=0.
- op  input  3  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MTHI, 7 MTLO.
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  input  WIDTH  rt operand (divisor / multiplier).
- abort  input  1  cancel in-flight operation.
- busy  output  1  engine computing; core must stall any HI/LO access.
- done  output  1  one-cycle pulse: hi/lo just updated by a MULT/DIV/MADD.
- div_by_zero  output  1  one-cycle pulse, coincident with done, for a DIV/DIVU with b=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state): hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM to IDLE, counter=0.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - If start=1 and op in {6,7}, the accept edge writes hi=a (MTHI) or lo=a (MTLO). No busy, no done.
  - If start=1 and op in {0..5}, latch op, magnitudes of a and b (signed ops use two's-complement abs), result sign flags, and the current {hi,lo} for MADD. Counter=0, go to CALC, busy=1 from the accept edge.
- DIV/DIVU with b=0:
  - Takes the early-out path: IDLE -> FIX directly.
  - Result is hi=a, lo={WIDTH{1}}, div_by_zero=1 with done. Latency is 2 cycles.
- CALC runs one iteration per cycle for WIDTH cycles; counter 0..WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, remainder of WIDTH+1 bits.
  - On counter=WIDTH-1, go to FIX.
- FIX (one cycle):
  - Apply sign correction. Product is negated if the operand signs differ (signed ops only).
  - For DIV, quotient is negated if signs differ; remainder takes the sign of the dividend.
  - MADD/MADDU: {hi,lo} = latched {hi,lo} + product, modulo 2^(2*WIDTH); signed and unsigned use the same add after correction.
  - Write hi (upper product / remainder) and lo (lower product / quotient).
  - Assert done for exactly the following cycle. busy=0 from that edge. Return to IDLE.
- Latency: start edge k gives hi/lo valid and done=1 after edge k+WIDTH+1. busy is high for WIDTH+1 cycles.
- Overflow case: signed DIV of MIN by -1 gives lo=MIN, hi=0. The truncated magnitude result is used; no flag.
- start while busy=1 is ignored with no queueing; the core must hold the request.
- Simultaneous done and start in the same cycle: start is accepted, because busy is already 0.
- abort=1 in CALC/FIX: return to IDLE on that edge, busy=0, hi/lo unchanged, no done. abort in IDLE has no effect. abort has priority over start in the same cycle.
- hi/lo never change mid-operation; they update only at the FIX edge, MTHI/MTLO, or reset.
- Operand inputs are don't-care after the accept edge.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001, done pulse of 1 cycle, busy high for exactly 33 cycles.
- MULT a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. Then MADD a=2, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFDC.
- Divide cases:
  - DIV a=-17, b=5 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2).
  - DIVU a=100, b=7 -> lo=14, hi=2.
  - DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done and div_by_zero at cycle 2, hi=0x1234, lo=0xFFFFFFFF. Next op accepted immediately after.
- Start MULT, pulse abort at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values. Also check that start with busy=1 is ignored.
- Assert rst at cycle 5 of DIV -> all outputs 0 immediately. MTHI a=0xA5A5A5A5 then MTLO a=0x5A5A5A5A -> hi/lo updated on each accept edge, no done.
